// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: opcode constants, FSM state encoding, mux-select encodings,
// the packed control word driven by the output decoder, and an opcode
// legality helper.
package mips_pkg;

   // Opcodes (instruction bits [31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // FSM states; the numeric values are visible on state_dbg
   typedef enum logic [3:0] {
      S_START   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   // ALU-B mux selects
   localparam logic [1:0] ALUB_REG   = 2'd0;
   localparam logic [1:0] ALUB_FOUR  = 2'd1;
   localparam logic [1:0] ALUB_IMM   = 2'd2;
   localparam logic [1:0] ALUB_IMMSH = 2'd3;

   // PC-source mux selects (3 is reserved)
   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;

   // ALU operation classes
   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   // Datapath control word (everything except illegal_op and state_dbg)
   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state -> control-word decoder for the multicycle MIPS FSM.
// Ports:
//   state     in   current FSM state encoding
//   mem_ready in   memory handshake, qualifies the FETCH PC/IR loads
//   ctrl      out  datapath enables and mux selects
module mips_mc_outdec
   import mips_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state_t'(state))
         S_FETCH: begin
            // IR and PC+4 only commit once the instruction word is on the bus
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = ALUB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PCS_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            // Branch target precompute: PC + (imm << 2)
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = ALUB_IMMSH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl.iord = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
            ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCS_ALUOUT;
            ctrl.branch    = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.reg_write  = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_src   = PCS_JUMP;
            ctrl.pc_write = 1'b1;
         end
         default: ctrl = '0;  // S_START and unused encodings
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Holds the state register and next-state logic; the per-state control word
// comes from mips_mc_outdec.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   opcode          IR[31:26]
//   mem_ready       memory access completes this cycle
//   pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, alu_op, pc_src   datapath controls
//   illegal_op      one-cycle pulse in DECODE on an unsupported opcode
//   state_dbg       current state encoding
module mips_mc_control
   import mips_pkg::*;
#(
   parameter int unsigned OPW = 6,
   parameter int unsigned STW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           branch,
   output logic           iord,
   output logic           mem_write,
   output logic           ir_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     alu_op,
   output logic [1:0]     pc_src,
   output logic           illegal_op,
   output logic [STW-1:0] state_dbg
);

   state_t state_q, state_d;
   ctrl_t  ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_START;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_START;
      case (state_q)
         S_START:  state_d = S_FETCH;
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               state_d = S_MEMADR;
            end else if (opcode == OP_RTYPE) begin
               state_d = S_EXECUTE;
            end else if (opcode == OP_BEQ) begin
               state_d = S_BRANCH;
            end else if (opcode == OP_ADDI) begin
               state_d = S_ADDIEX;
            end else if (opcode == OP_J) begin
               state_d = S_JUMP;
            end else begin
               state_d = S_FETCH;
            end
         end
         // IR is frozen outside FETCH, so only lw/sw can reach here
         S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         default:   state_d = S_START;
      endcase
   end

   mips_mc_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_write   = ctrl.pc_write;
   assign branch     = ctrl.branch;
   assign iord       = ctrl.iord;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign pc_src     = ctrl.pc_src;

   assign illegal_op = (state_q == S_DECODE) && !is_legal(opcode);
   assign state_dbg  = STW'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed scenarios followed by a
// random instruction stream, checked cycle by cycle against a reference model
// that expands each opcode into its list of phases.
module tb_mips_mc_control;

   // Phase numbering mirrors the documented state_dbg values
   localparam int P_START = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                  P_MEMWB = 5, P_MEMWR = 6, P_EXECUTE = 7, P_ALUWB = 8, P_BRANCH = 9,
                  P_ADDIEX = 10, P_ADDIWB = 11, P_JUMP = 12;

   localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                          C_BEQ = 6'b000100, C_ADDI = 6'b001000, C_J = 6'b000010;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
      logic [3:0] st;
   } cw_t;

   logic       clk, rst, mem_ready;
   logic [5:0] opcode;
   logic       pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg;
   logic       reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   int plan[$];

   mips_mc_control #(.OPW(6), .STW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .branch     (branch),
      .iord       (iord),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .illegal_op (illegal_op),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic cw_t observe();
      return {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
              alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state_dbg};
   endfunction

   // Expected outputs for a phase, straight from the per-state output table
   function automatic cw_t model_word(input int ph, input logic mr, input logic [5:0] op);
      cw_t c;
      c = '0;
      c.st = 4'(ph);
      case (ph)
         P_FETCH:   begin c.alu_src_b = 2'd1; c.ir_write = mr; c.pc_write = mr; end
         P_DECODE:  begin
            c.alu_src_b = 2'd3;
            c.illegal_op = !(op inside {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J});
         end
         P_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
         P_MEMRD:   c.iord = 1'b1;
         P_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         P_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
         P_EXECUTE: begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
         P_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         P_BRANCH:  begin
            c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.branch = 1'b1;
         end
         P_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
         P_ADDIWB:  c.reg_write = 1'b1;
         P_JUMP:    begin c.pc_src = 2'd2; c.pc_write = 1'b1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

   function automatic void build_plan(input logic [5:0] op);
      plan.delete();
      plan.push_back(P_FETCH);
      plan.push_back(P_DECODE);
      case (op)
         C_LW:   begin plan.push_back(P_MEMADR); plan.push_back(P_MEMRD);
                       plan.push_back(P_MEMWB); end
         C_SW:   begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWR); end
         C_R:    begin plan.push_back(P_EXECUTE); plan.push_back(P_ALUWB); end
         C_BEQ:  plan.push_back(P_BRANCH);
         C_ADDI: begin plan.push_back(P_ADDIEX); plan.push_back(P_ADDIWB); end
         C_J:    plan.push_back(P_JUMP);
         default: ;
      endcase
   endfunction

   task automatic check(input string tag, input cw_t obs, input cw_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
      n_cmp++;
      assert (!(obs.pc_write && obs.branch) && !(obs.mem_write && obs.ir_write)) else begin
         n_err++;
         $error("FAIL %s_invariant: observed %h required no strobe overlap", tag, obs);
      end
   endtask

   task automatic step(input logic mr, input logic [5:0] op, input int ph, input string tag);
      @(negedge clk);
      mem_ready = mr;
      opcode    = op;
      #1;
      check(tag, observe(), model_word(ph, mr, op));
   endtask

   // Run one instruction from FETCH. waits < 0: random mem_ready everywhere;
   // otherwise FETCH is immediate and each memory phase stalls exactly 'waits'.
   task automatic run_instr(input logic [5:0] op, input int waits, input string tag);
      int idx = 0;
      int stall = 0;
      logic mr;
      build_plan(op);
      while (idx < plan.size()) begin
         if (waits < 0) begin
            mr = ($urandom_range(0, 3) != 0) || (stall >= 5);
         end else if (plan[idx] == P_MEMRD || plan[idx] == P_MEMWR) begin
            mr = (stall >= waits);
         end else begin
            mr = 1'b1;
         end
         step(mr, op, plan[idx], $sformatf("%s_ph%0d", tag, plan[idx]));
         if ((plan[idx] inside {P_FETCH, P_MEMRD, P_MEMWR}) && !mr) begin
            stall++;
         end else begin
            idx++;
            stall = 0;
         end
      end
   endtask

   initial begin
      logic [5:0] rop;
      logic [5:0] legal_ops[6];
      legal_ops = '{C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J};
      rst = 1'b1;
      mem_ready = 1'b1;
      opcode = C_LW;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_start", observe(), cw_t'(0));

      // Directed: lw, sw with 3 stall cycles, beq, illegal, remaining types
      run_instr(C_LW, 0, "lw");
      run_instr(C_SW, 3, "sw_stall3");
      run_instr(C_BEQ, 0, "beq");
      run_instr(6'b111111, 0, "illegal");
      run_instr(C_R, 0, "rtype");
      run_instr(C_ADDI, 0, "addi");
      run_instr(C_J, 0, "jump");
      run_instr(C_LW, 2, "lw_stall2");

      // Reset while a store is waiting in MEMWR
      step(1'b1, C_SW, P_FETCH, "rstmid_fetch");
      step(1'b1, C_SW, P_DECODE, "rstmid_decode");
      step(1'b1, C_SW, P_MEMADR, "rstmid_memadr");
      step(1'b0, C_SW, P_MEMWR, "rstmid_memwr");
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      check("rstmid_hold", observe(), model_word(P_MEMWR, 1'b0, C_SW));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_start", observe(), cw_t'(0));

      // Random instruction stream with random memory stalls
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            do rop = 6'($urandom); while (rop inside {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J});
         end else begin
            rop = legal_ops[$urandom_range(0, 5)];
         end
         run_instr(rop, -1, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard bound in case the bench itself stalls
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion required finish before limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the opcode latched in the instruction register.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives every datapath enable and every mux select, including the 2-bit selects of the 4-input ALU-B and PC-source muxes directly downstream.

Parameters:
- OPW, 6, opcode width
- STW, 4, state register width (debug output width)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  OPW  instruction bits [31:26] from IR
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- branch  out  1  PC load qualified by ALU zero (datapath ANDs it)
- iord  out  1  0 = memory addr from PC, 1 = from ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- alu_op  out  2  0 = add, 1 = sub, 2 = funct decode
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reserved
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state_dbg  out  STW  current state encoding

Behaviour:
- Reset:
  - rst sampled on the rising edge; state <= START.
  - In START, all outputs are 0 and state_dbg = 0.
  - START -> FETCH unconditionally on the next edge.
  - rst asserted mid-instruction abandons the instruction; no write strobe is asserted on the reset edge's following cycle.
- Outputs:
  - Moore decode of state, except FETCH pc_write/ir_write, which are qualified by mem_ready.
  - Outputs not listed for a state are 0.
- States, asserted outputs and transitions:
  - FETCH: iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0; ir_write = pc_write = mem_ready. Stay while mem_ready=0; else -> DECODE.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
    - Next state by opcode: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
    - Any other opcode: illegal_op=1 for this cycle, -> FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1. Stay while mem_ready=0; else -> MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. -> FETCH.
  - MEMWR: iord=1, mem_write=1 held until mem_ready=1. Stay while mem_ready=0; else -> FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=2. -> ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, branch=1. -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. -> ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. -> FETCH.
  - JUMP: pc_src=2, pc_write=1. -> FETCH.
- Opcode decode:
  - opcode is sampled in DECODE and again in MEMADR; the IR is stable because ir_write=0 outside FETCH.
  - Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Invariants:
  - pc_write and branch are never both 1.
  - mem_write and ir_write are never both 1.
  - Unreachable state encodings -> START.
- Cycle counts with mem_ready tied 1:
  - lw: 5; sw: 4; R-type: 4; addi: 4; beq: 3; j: 3; illegal: 2.
- Each memory-state wait cycle adds 1.

Decomposition:
- Shared package mips_pkg:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - state encodings (S_START=0 .. S_JUMP=12)
  - select encodings (ALUB_REG, ALUB_FOUR, ALUB_IMM, ALUB_IMMSH; PCS_ALU, PCS_ALUOUT, PCS_JUMP; ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
- One sub-module, mips_mc_outdec: purely combinational state -> control-word decode.
- The top module keeps the state register and the next-state logic.

Test Plan:
- rst=1 for 2 cycles, then 0, mem_ready=1 -> all outputs 0 in START; next cycle FETCH with ir_write=1, pc_write=1, alu_src_b=1.
- lw (opcode 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1, mem_to_reg=1 only in cycle 5.
- sw with mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, then FETCH; no reg_write.
- beq (000100) -> BRANCH has alu_op=1, pc_src=1, branch=1, pc_write=0; 3 cycles total.
- opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, return to FETCH; no write strobes.
- rst asserted during MEMWR -> next cycle START; mem_write=0, reg_write=0.
